// File: rtl/op_pkg.sv
// Shared core-wide configuration constants.
package op_pkg;
  parameter int SUPER_SCALAR_WIDTH = 4;
endpackage : op_pkg

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode bundle handshake: the fetch stage is master, decode is slave.
interface fetch_unit_if #(
  parameter int SSW = op_pkg::SUPER_SCALAR_WIDTH
);
  logic              decode_valid;
  logic              decode_ready;
  logic [63:0]       decode_pc;
  logic [SSW*32-1:0] decode_instr;
  logic [SSW-1:0]    decode_lane_valid;

  modport master (
    output decode_valid, decode_pc, decode_instr, decode_lane_valid,
    input  decode_ready
  );

  modport slave (
    input  decode_valid, decode_pc, decode_instr, decode_lane_valid,
    output decode_ready
  );
endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Fetch stage: turns predicted PCs into instruction bundles from L0/L1I lines and queues them for decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int CACHE_LINE_WIDTH   = 64,
  parameter int SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter int FQ_DEPTH           = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,
  input  logic                          bp_pc_valid,
  input  logic [63:0]                   bp_pc,
  input  logic                          bp_l0_valid,
  input  logic                          bp_l1i_valid,
  input  logic [CACHE_LINE_WIDTH*8-1:0] bp_l0_cacheline,
  input  logic                          l1i_valid,
  input  logic [CACHE_LINE_WIDTH*8-1:0] l1i_cacheline,
  input  logic                          flush,
  output logic                          fetch_ready,
  fetch_unit_if.master                  dec
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]                   perf_bundles,
  output logic [63:0]                   perf_miss_stall
`endif
);

  localparam int SSW      = SUPER_SCALAR_WIDTH;
  localparam int OFF_BITS = $clog2(CACHE_LINE_WIDTH);
  localparam int WORDS    = CACHE_LINE_WIDTH / 4;
  localparam int CW       = $clog2(FQ_DEPTH + 1);
  localparam int PW       = $clog2(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_L1I, DISCARD} state_t;

  typedef struct packed {
    logic [63:0]       pc;
    logic [SSW*32-1:0] instr;
    logic [SSW-1:0]    lane_valid;
  } bundle_t;

  state_t        state;
  logic [63:2]   miss_pc;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  bundle_t       fq_mem [FQ_DEPTH];

  logic    accept;
  logic    push;
  logic    pop;
  bundle_t push_bundle;
  bundle_t head;
  logic    unused_pc_bits;

  // Slice up to SSW words starting at the PC's word offset; lanes past the line end stay zero.
  function automatic bundle_t build_bundle(input logic [63:2] pc_w,
                                           input logic [CACHE_LINE_WIDTH*8-1:0] line);
    bundle_t b;
    int      word;
    b    = '0;
    b.pc = {pc_w, 2'b00};
    for (int i = 0; i < SSW; i++) begin
      word = int'(pc_w[OFF_BITS-1:2]) + i;
      if (word < WORDS) begin
        b.instr[32*i +: 32] = line[32*word +: 32];
        b.lane_valid[i]     = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign unused_pc_bits = ^bp_pc[1:0];

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    fetch_ready = (state == IDLE) && (count < CW'(FQ_DEPTH)) && rst_N_in;
    accept      = bp_pc_valid && fetch_ready;
    push        = !flush && ((accept && bp_l0_valid) || (state == WAIT_L1I && l1i_valid));
    pop         = (count != '0) && dec.decode_ready;
    if (state == WAIT_L1I) push_bundle = build_bundle(miss_pc, l1i_cacheline);
    else                   push_bundle = build_bundle(bp_pc[63:2], bp_l0_cacheline);
  end

  assign head                  = fq_mem[head_ptr];
  assign dec.decode_valid      = (count != '0);
  assign dec.decode_pc         = head.pc;
  assign dec.decode_instr      = head.instr;
  assign dec.decode_lane_valid = head.lane_valid;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state    <= IDLE;
      miss_pc  <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      // NOTE: the queue storage is reset because it drives decode outputs directly and must read zero.
      for (int i = 0; i < FQ_DEPTH; i++) fq_mem[i] <= '0;
    end else begin
      if (flush) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fq_mem[tail_ptr] <= push_bundle;
          tail_ptr         <= next_ptr(tail_ptr);
        end
        if (pop) head_ptr <= next_ptr(head_ptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      case (state)
        IDLE: begin
          if (!flush && accept && !bp_l0_valid && bp_l1i_valid) begin
            miss_pc <= bp_pc[63:2];
            state   <= WAIT_L1I;
          end
        end
        WAIT_L1I: begin
          // A flush with no return in the same cycle leaves one stale L1I response to swallow.
          if (flush)          state <= l1i_valid ? IDLE : DISCARD;
          else if (l1i_valid) state <= IDLE;
        end
        DISCARD: begin
          if (!flush && l1i_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      perf_bundles    <= '0;
      perf_miss_stall <= '0;
    end else begin
      if (push && perf_bundles != '1) perf_bundles <= perf_bundles + 64'd1;
      if (state != IDLE && perf_miss_stall != '1) perf_miss_stall <= perf_miss_stall + 64'd1;
    end
  end
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected bundles, a negedge monitor checks decode transfers.
module tb_fetch_unit;

  logic         clk_in;
  logic         rst_N_in;
  logic         bp_pc_valid;
  logic [63:0]  bp_pc;
  logic         bp_l0_valid;
  logic         bp_l1i_valid;
  logic [511:0] bp_l0_cacheline;
  logic         l1i_valid;
  logic [511:0] l1i_cacheline;
  logic         flush;
  logic         fetch_ready;

  logic [511:0] line_a;
  logic [511:0] line_b;

  typedef struct {
    logic [63:0]  pc;
    logic [127:0] instr;
    logic [3:0]   lv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fetch_unit_if #(.SSW(4)) dec_if ();

  fetch_unit #(
    .CACHE_LINE_WIDTH  (64),
    .SUPER_SCALAR_WIDTH(4),
    .FQ_DEPTH          (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_N_in       (rst_N_in),
    .bp_pc_valid    (bp_pc_valid),
    .bp_pc          (bp_pc),
    .bp_l0_valid    (bp_l0_valid),
    .bp_l1i_valid   (bp_l1i_valid),
    .bp_l0_cacheline(bp_l0_cacheline),
    .l1i_valid      (l1i_valid),
    .l1i_cacheline  (l1i_cacheline),
    .flush          (flush),
    .fetch_ready    (fetch_ready),
    .dec            (dec_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic offer_l0(input logic [63:0] pc);
    bp_pc_valid     = 1'b1;
    bp_pc           = pc;
    bp_l0_valid     = 1'b1;
    bp_l1i_valid    = 1'b0;
    bp_l0_cacheline = line_a;
  endtask

  task automatic offer_miss(input logic [63:0] pc);
    bp_pc_valid  = 1'b1;
    bp_pc        = pc;
    bp_l0_valid  = 1'b0;
    bp_l1i_valid = 1'b1;
  endtask

  task automatic idle_bp();
    bp_pc_valid  = 1'b0;
    bp_l0_valid  = 1'b0;
    bp_l1i_valid = 1'b0;
  endtask

  task automatic expect_b(input logic [63:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] i2, input logic [31:0] i3, input logic [3:0] lv);
    exp_t e;
    e.pc    = pc;
    e.instr = {i3, i2, i1, i0};
    e.lv    = lv;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    dec_if.decode_ready = 1'b1;
    while ((sb.size() != 0 || dec_if.decode_valid) && n < 40) begin
      tick();
      n++;
    end
    check("drain_scoreboard_empty", 128'(sb.size()), 128'd0);
  endtask

  // Monitor: every accepted decode transfer must match the oldest expected bundle.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_N_in && dec_if.decode_valid && dec_if.decode_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_bundle", dec_if.decode_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("bundle_pc", dec_if.decode_pc, mon_e.pc);
          check("bundle_instr", dec_if.decode_instr, mon_e.instr);
          check("bundle_lane_valid", dec_if.decode_lane_valid, mon_e.lv);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      line_a[8*k +: 8] = 8'(k);
      line_b[8*k +: 8] = 8'(8'h80 + k);
    end
    rst_N_in            = 1'b0;
    idle_bp();
    bp_pc               = '0;
    bp_l0_cacheline     = '0;
    l1i_valid           = 1'b0;
    l1i_cacheline       = '0;
    flush               = 1'b0;
    dec_if.decode_ready = 1'b0;

    // Reset state
    #1;
    check("reset_decode_valid", dec_if.decode_valid, 1'b0);
    check("reset_decode_pc", dec_if.decode_pc, 64'd0);
    check("reset_decode_instr", dec_if.decode_instr, 128'd0);
    check("reset_lane_valid", dec_if.decode_lane_valid, 4'd0);
    check("reset_fetch_ready", fetch_ready, 1'b0);
    tick();
    tick();
    check("in_reset_fetch_ready", fetch_ready, 1'b0);
    rst_N_in = 1'b1;
    #1;
    check("post_reset_fetch_ready", fetch_ready, 1'b1);

    // L0 hits back to back: full bundle then line-end truncation
    dec_if.decode_ready = 1'b1;
    offer_l0(64'h1008);
    expect_b(64'h1008, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110, 32'h17161514, 4'b1111);
    tick();
    check("l0_latency_valid", dec_if.decode_valid, 1'b1);
    offer_l0(64'hFFFF_0000_0000_1038);
    expect_b(64'hFFFF_0000_0000_1038, 32'h3B3A3938, 32'h3F3E3D3C, 32'h0, 32'h0, 4'b0011);
    tick();
    check("l0_back_to_back_valid", dec_if.decode_valid, 1'b1);
    idle_bp();
    drain();

    // L1I miss with the predictor holding a new PC during the stall
    offer_miss(64'h2000);
    expect_b(64'h2000, 32'h83828180, 32'h87868584, 32'h8B8A8988, 32'h8F8E8D8C, 4'b1111);
    check("miss_accept_ready", fetch_ready, 1'b1);
    tick();
    offer_l0(64'h3000);
    check("miss_stall_ready_1", fetch_ready, 1'b0);
    tick();
    check("miss_stall_ready_2", fetch_ready, 1'b0);
    tick();
    l1i_valid     = 1'b1;
    l1i_cacheline = line_b;
    check("miss_stall_ready_3", fetch_ready, 1'b0);
    tick();
    l1i_valid = 1'b0;
    idle_bp();
    check("miss_bundle_visible", dec_if.decode_valid, 1'b1);
    check("miss_ready_restored", fetch_ready, 1'b1);
    drain();

    // Backpressure: four queued, fifth waits for one pop
    dec_if.decode_ready = 1'b0;
    offer_l0(64'h1000);
    expect_b(64'h1000, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 4'b1111);
    tick();
    offer_l0(64'h1010);
    expect_b(64'h1010, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C, 4'b1111);
    tick();
    offer_l0(64'h1024);
    expect_b(64'h1024, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C, 32'h33323130, 4'b1111);
    tick();
    offer_l0(64'h1034);
    expect_b(64'h1034, 32'h37363534, 32'h3B3A3938, 32'h3F3E3D3C, 32'h0, 4'b0111);
    check("bp_ready_before_full", fetch_ready, 1'b1);
    tick();
    offer_l0(64'h103F);
    expect_b(64'h103C, 32'h3F3E3D3C, 32'h0, 32'h0, 32'h0, 4'b0001);
    check("bp_full_ready", fetch_ready, 1'b0);
    tick();
    check("bp_full_ready_held", fetch_ready, 1'b0);
    check("bp_full_valid", dec_if.decode_valid, 1'b1);
    dec_if.decode_ready = 1'b1;
    tick();
    dec_if.decode_ready = 1'b0;
    check("bp_ready_after_pop", fetch_ready, 1'b1);
    tick();
    idle_bp();
    check("bp_full_again", fetch_ready, 1'b0);
    drain();

    // Flush in IDLE drops a same-cycle L0 accept
    offer_l0(64'h1000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_bp();
    check("flush_drops_accept", dec_if.decode_valid, 1'b0);
    check("flush_idle_ready", fetch_ready, 1'b1);

    // Flush during a miss: queue cleared, stale return discarded
    dec_if.decode_ready = 1'b0;
    offer_l0(64'h1000);
    tick();
    offer_miss(64'h2000);
    tick();
    idle_bp();
    check("flush_pre_ready", fetch_ready, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_clears_queue", dec_if.decode_valid, 1'b0);
    check("discard_ready_low", fetch_ready, 1'b0);
    tick();
    check("discard_ready_held", fetch_ready, 1'b0);
    l1i_valid     = 1'b1;
    l1i_cacheline = line_b;
    tick();
    l1i_valid = 1'b0;
    check("discard_drops_return", dec_if.decode_valid, 1'b0);
    check("discard_exit_ready", fetch_ready, 1'b1);
    dec_if.decode_ready = 1'b1;
    tick();
    tick();

    // Flush coinciding with the L1I return goes straight back to IDLE
    offer_miss(64'h2000);
    tick();
    idle_bp();
    flush     = 1'b1;
    l1i_valid = 1'b1;
    tick();
    flush     = 1'b0;
    l1i_valid = 1'b0;
    check("flush_with_return_ready", fetch_ready, 1'b1);
    check("flush_with_return_valid", dec_if.decode_valid, 1'b0);

    // Reset mid-operation: two bundles queued and a miss pending
    dec_if.decode_ready = 1'b0;
    offer_l0(64'h1000);
    tick();
    offer_l0(64'h1010);
    tick();
    offer_miss(64'h2000);
    tick();
    idle_bp();
    check("pre_reset_valid", dec_if.decode_valid, 1'b1);
    rst_N_in = 1'b0;
    #1;
    check("midrst_decode_valid", dec_if.decode_valid, 1'b0);
    check("midrst_decode_pc", dec_if.decode_pc, 64'd0);
    check("midrst_decode_instr", dec_if.decode_instr, 128'd0);
    check("midrst_lane_valid", dec_if.decode_lane_valid, 4'd0);
    check("midrst_fetch_ready", fetch_ready, 1'b0);
    tick();
    rst_N_in = 1'b1;
    #1;
    check("after_midrst_ready", fetch_ready, 1'b1);
    l1i_valid     = 1'b1;
    l1i_cacheline = line_b;
    tick();
    l1i_valid = 1'b0;
    check("after_midrst_no_bundle", dec_if.decode_valid, 1'b0);
    check("after_midrst_ready_idle", fetch_ready, 1'b1);

    // Normal operation resumes
    dec_if.decode_ready = 1'b1;
    offer_l0(64'h1008);
    expect_b(64'h1008, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110, 32'h17161514, 4'b1111);
    tick();
    idle_bp();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
